tick_controller: RTL and testbench

TICK_CONTROLLER -- requirements
Module: tick_controller

---
 rtl/tick_controller.sv | 144 ++++++++++++++
 tb/tb_tick_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_controller.sv
// Run controller: emits tick_count ticks spaced by a speed-selected period,
// with pause/abort control and a one-cycle done pulse at completion.
module tick_controller #(
  parameter logic [27:0] PERIOD_0 = 28'd1,
  parameter logic [27:0] PERIOD_1 = 28'd25000000,
  parameter logic [27:0] PERIOD_2 = 28'd50000000,
  parameter logic [27:0] PERIOD_3 = 28'd100000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [1:0] speed,
  input  logic [7:0] tick_count,
  output logic       tick,
  output logic       done,
  output logic       busy,
  output logic [7:0] ticks_left,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] cnt_q, cnt_d;
  logic [27:0] period_q, period_d;
  logic [7:0]  ticks_left_q, ticks_left_d;
  logic        tick_q, tick_d;
  logic        done_q, done_d;

  logic        launch;
  logic        wrap;
  logic        last_tick;
  logic [27:0] period_sel;

  assign launch    = start && (tick_count != 8'd0);
  assign wrap      = (cnt_q == period_q - 28'd1);
  assign last_tick = (ticks_left_q == 8'd1);

  always_comb begin
    unique case (speed)
      2'd0:    period_sel = PERIOD_0;
      2'd1:    period_sel = PERIOD_1;
      2'd2:    period_sel = PERIOD_2;
      default: period_sel = PERIOD_3;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= PERIOD_0;
      ticks_left_q <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      ticks_left_q <= ticks_left_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
    end
  end

  // Priority inside a run: abort, then pause, then the period wrap.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = RUN;
      RUN, PAUSE: begin
        if (abort)                  state_d = IDLE;
        else if (pause)             state_d = PAUSE;
        else if (wrap && last_tick) state_d = DONE;
        else                        state_d = RUN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leaving PAUSE counts on the same edge, so a pause costs exactly the
  // number of edges at which pause was sampled high.
  always_comb begin
    cnt_d        = cnt_q;
    period_d     = period_q;
    ticks_left_d = ticks_left_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          period_d     = period_sel;
          ticks_left_d = tick_count;
          cnt_d        = '0;
        end
      end
      RUN, PAUSE: begin
        if (abort) begin
          cnt_d        = '0;
          ticks_left_d = '0;
        end else if (!pause) begin
          if (wrap) begin
            cnt_d        = '0;
            ticks_left_d = ticks_left_q - 8'd1;
            tick_d       = 1'b1;
            done_d       = last_tick;
          end else begin
            cnt_d = cnt_q + 28'd1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          cnt_d        = '0;
          ticks_left_d = '0;
        end
      end
      default: begin
        cnt_d        = '0;
        ticks_left_d = '0;
      end
    endcase
  end

  always_comb begin
    tick       = tick_q;
    done       = done_q;
    busy       = (state_q == RUN) || (state_q == PAUSE);
    ticks_left = ticks_left_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_tick_controller.sv
// Scoreboard bench for tick_controller: a cycle-level reference model pushes
// expected outputs per clock; a monitor pops and compares after each edge.
module tb_tick_controller;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] speed;
  logic [7:0] tick_count;
  logic       tick;
  logic       done;
  logic       busy;
  logic [7:0] ticks_left;
  logic [1:0] state;

  tick_controller #(
    .PERIOD_0(28'd1),
    .PERIOD_1(28'd4),
    .PERIOD_2(28'd8),
    .PERIOD_3(28'd16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .speed      (speed),
    .tick_count (tick_count),
    .tick       (tick),
    .done       (done),
    .busy       (busy),
    .ticks_left (ticks_left),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int st;
    int tk;
    int dn;
    int bz;
    int left;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference model: phase 0=idle 1=run 2=pause 3=done.
  int m_phase, m_cnt, m_p, m_left, m_tick, m_done;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int period_of(input logic [1:0] sp);
    case (sp)
      2'd0:    return 1;
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 16;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_p = 1; m_left = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_step(input logic st, input logic pa, input logic ab,
                            input logic [1:0] sp, input logic [7:0] tc);
    exp_t e;
    m_tick = 0;
    m_done = 0;
    case (m_phase)
      0: if (st && tc != 0) begin
        m_p = period_of(sp); m_left = int'(tc); m_cnt = 0; m_phase = 1;
      end
      1, 2: begin
        if (ab) begin
          m_phase = 0; m_cnt = 0; m_left = 0;
        end else if (pa) begin
          m_phase = 2;
        end else begin
          m_phase = 1;
          if (m_cnt == m_p - 1) begin
            m_cnt = 0;
            m_left = m_left - 1;
            m_tick = 1;
            if (m_left == 0) begin
              m_phase = 3;
              m_done = 1;
            end
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      default: begin
        m_phase = 0;
        if (ab) begin m_cnt = 0; m_left = 0; end
      end
    endcase
    e.st = m_phase; e.tk = m_tick; e.dn = m_done;
    e.bz = (m_phase == 1 || m_phase == 2) ? 1 : 0;
    e.left = m_left; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic drive(input logic st, input logic pa, input logic ab,
                       input logic [1:0] sp, input logic [7:0] tc);
    @(negedge clock);
    start = st; pause = pa; abort = ab; speed = sp; tick_count = tc;
    model_step(st, pa, ab, sp, tc);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_left"}, int'(ticks_left), 0);
    check({tag, "_cnt"}, int'(dut.cnt_q), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", int'(state), e.st);
        check("tick", int'(tick), e.tk);
        check("done", int'(done), e.dn);
        check("busy", int'(busy), e.bz);
        check("ticks_left", int'(ticks_left), e.left);
        check("cnt", int'(dut.cnt_q), e.cnt);
      end
    end
  end

  initial begin : stimulus
    logic st, pa, ab;
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    speed = 2'd0; tick_count = 8'd0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // speed 1, 3 ticks: ticks at +4, +8, +12, done with the last, then idle.
    drive(1'b1, 1'b0, 1'b0, 2'd1, 8'd3);
    idle_cycles(14);

    // speed 0, 5 ticks: tick every clock.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'd5);
    idle_cycles(7);

    // speed 2, 2 ticks, pause for 10 edges once cnt reaches 3.
    drive(1'b1, 1'b0, 1'b0, 2'd2, 8'd2);
    idle_cycles(3);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 2'd2, 8'd0);
    idle_cycles(20);

    // speed 3, 4 ticks, abort on the 20th clock after start.
    drive(1'b1, 1'b0, 1'b0, 2'd3, 8'd4);
    idle_cycles(19);
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
    idle_cycles(4);

    // Zero-length start ignored; restart mid-run with new speed ignored.
    drive(1'b1, 1'b0, 1'b0, 2'd2, 8'd0);
    idle_cycles(2);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 8'd2);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 2'd3, 8'd9);
    idle_cycles(6);

    // Asynchronous reset while paused, then a fresh run.
    drive(1'b1, 1'b0, 1'b0, 2'd2, 8'd3);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 2'd2, 8'd0);
    @(posedge clock);
    #3;
    check("pre_reset_state", int'(state), 2);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd1, 8'd2);
    idle_cycles(10);

    // Randomized traffic; abort is only raised inside a run.
    for (int i = 0; i < 2000; i++) begin
      st = ($urandom_range(0, 3) == 0);
      pa = ($urandom_range(0, 9) == 0);
      ab = (m_phase != 0) && ($urandom_range(0, 59) == 0);
      drive(st, pa, ab, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 5)));
    end

    @(posedge clock);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
